// File: rtl/apb_event_completer.sv
// apb_event_completer: APB completer that counts, clears and reads back three event counters
module apb_event_completer #(
  parameter int WAIT_CYCLES = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             apb_psel_i,
  input  logic             apb_penable_i,
  input  logic [31:0]      apb_paddr_i,
  input  logic             apb_pwrite_i,
  input  logic [31:0]      apb_pwdata_i,
  output logic             apb_pready_o,
  output logic [31:0]      apb_prdata_o,
  output logic             apb_pslverr_o,
  output logic [CNT_W-1:0] cnt_a_o,
  output logic [CNT_W-1:0] cnt_b_o,
  output logic [CNT_W-1:0] cnt_c_o,
  output logic [2:0]       evt_pulse_o,
  output logic             proto_err_o
);
  localparam logic [3:0] WAIT_LIM = 4'(WAIT_CYCLES);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, state_nxt;
  logic [31:0] addr_q, addr_nxt;
  logic [3:0] wait_q, wait_nxt;
  logic err_q, err_nxt;
  logic [CNT_W-1:0] cnt_q [3];
  logic [2:0] pulse_q, hit;
  logic [CNT_W-1:0] rd_cnt;
  logic mapped, complete, unused;
  assign unused = ^apb_pwdata_i[30:0];
  assign hit = {addr_q == 32'hCAFE_0000, addr_q == 32'hBAFF_0000, addr_q == 32'hABBA_0000};
  assign mapped = |hit;
  assign apb_pready_o = state == ACCESS && wait_q == WAIT_LIM;
  assign complete = apb_pready_o && apb_psel_i && apb_penable_i;
  assign rd_cnt = hit[0] ? cnt_q[0] : hit[1] ? cnt_q[1] : hit[2] ? cnt_q[2] : '0;
  assign apb_prdata_o = complete && !apb_pwrite_i ? 32'(rd_cnt) : 32'h0;
  assign apb_pslverr_o = complete && !mapped;
  assign cnt_a_o = cnt_q[0];
  assign cnt_b_o = cnt_q[1];
  assign cnt_c_o = cnt_q[2];
  assign evt_pulse_o = pulse_q;
  assign proto_err_o = err_q;
  // next state: setup captures the address, access waits, aborts and stray access phases flag an error
  always_comb begin
    state_nxt = state;
    wait_nxt = wait_q;
    addr_nxt = addr_q;
    err_nxt = err_q;
    if (state == IDLE) begin
      if (apb_psel_i && !apb_penable_i) begin
        state_nxt = ACCESS;
        wait_nxt = '0;
        addr_nxt = apb_paddr_i;
      end else if (apb_psel_i && apb_penable_i) err_nxt = 1'b1;
    end else if (!apb_psel_i || !apb_penable_i) begin
      state_nxt = IDLE;
      err_nxt = 1'b1;
    end else if (apb_pready_o) state_nxt = IDLE;
    else if (wait_q < WAIT_LIM) wait_nxt = wait_q + 4'd1;
  end
  // FSM, wait counter, captured address and sticky protocol error
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      wait_q <= '0;
      addr_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      wait_q <= wait_nxt;
      addr_q <= addr_nxt;
      err_q <= err_nxt;
    end
  // event counters: bit 31 clears, otherwise saturating increment with a one-cycle pulse
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt_q <= '{default: '0};
      pulse_q <= '0;
    end else begin
      pulse_q <= '0;
      for (int i = 0; i < 3; i++)
        if (complete && apb_pwrite_i && hit[i]) begin
          cnt_q[i] <= apb_pwdata_i[31] ? '0 : &cnt_q[i] ? cnt_q[i] : cnt_q[i] + CNT_W'(1);
          pulse_q[i] <= !apb_pwdata_i[31];
        end
    end
endmodule

// File: tb/tb_apb_event_completer.sv
// tb_apb_event_completer: directed checks of event counting, wait states, errors and reset
module tb_apb_event_completer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic cur = 1'b0;
  logic psel [2];
  logic pen [2];
  logic pwr [2];
  logic [31:0] paddr [2];
  logic [31:0] pwdata [2];
  logic rdy0, rdy1, serr0, serr1, perr0, perr1;
  logic [31:0] rd0, rd1;
  logic [15:0] a0, b0, c0;
  logic [1:0] a1, b1, c1;
  logic [2:0] ev0, ev1;
  logic rdy, serr;
  logic [31:0] rdat;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc;
  logic [31:0] rdata;
  logic err;
  assign rdy = cur ? rdy1 : rdy0;
  assign serr = cur ? serr1 : serr0;
  assign rdat = cur ? rd1 : rd0;
  always #5 clk = ~clk;
  apb_event_completer #(.WAIT_CYCLES(1), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .apb_psel_i(psel[0]), .apb_penable_i(pen[0]),
    .apb_paddr_i(paddr[0]), .apb_pwrite_i(pwr[0]), .apb_pwdata_i(pwdata[0]),
    .apb_pready_o(rdy0), .apb_prdata_o(rd0), .apb_pslverr_o(serr0),
    .cnt_a_o(a0), .cnt_b_o(b0), .cnt_c_o(c0), .evt_pulse_o(ev0), .proto_err_o(perr0)
  );
  apb_event_completer #(.WAIT_CYCLES(0), .CNT_W(2)) dut1 (
    .clk(clk), .reset(reset), .apb_psel_i(psel[1]), .apb_penable_i(pen[1]),
    .apb_paddr_i(paddr[1]), .apb_pwrite_i(pwr[1]), .apb_pwdata_i(pwdata[1]),
    .apb_pready_o(rdy1), .apb_prdata_o(rd1), .apb_pslverr_o(serr1),
    .cnt_a_o(a1), .cnt_b_o(b1), .cnt_c_o(c1), .evt_pulse_o(ev1), .proto_err_o(perr1)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask
  // one transfer on DUT cur, starting just after a rising edge and returning just after the completing edge
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] data,
                      output int n, output logic [31:0] rd, output logic e);
    bit done = 0;
    psel[cur] = 1'b1;
    pen[cur] = 1'b0;
    paddr[cur] = addr;
    pwr[cur] = wr;
    pwdata[cur] = data;
    @(posedge clk); #1;
    pen[cur] = 1'b1;
    n = 0;
    rd = '0;
    e = 1'b0;
    while (!done && n < 16) begin
      n++;
      @(negedge clk);
      if (rdy) begin
        done = 1;
        rd = rdat;
        e = serr;
      end
      @(posedge clk); #1;
    end
    if (!done) check("timeout", {31'b0, rdy}, 32'd1);
    psel[cur] = 1'b0;
    pen[cur] = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin
      psel[i] = 0; pen[i] = 0; pwr[i] = 0; paddr[i] = '0; pwdata[i] = '0;
    end
    psel[0] = 1; pen[0] = 1; paddr[0] = 32'hABBA_0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rdy", {31'b0, rdy0}, 0);
    check("rst_rdata", rd0, 0);
    check("rst_serr", {31'b0, serr0}, 0);
    check("rst_cnt", {a0, b0 | c0}, 0);
    check("rst_ev", {29'b0, ev0}, 0);
    check("rst_perr", {31'b0, perr0}, 0);
    psel[0] = 0; pen[0] = 0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    xfer(32'hABBA_0000, 1, 32'h1, cyc, rdata, err);
    check("a_cycles", cyc, 2);
    check("a_serr", {31'b0, err}, 0);
    check("a_cnt", {16'b0, a0}, 1);
    check("a_pulse", {29'b0, ev0}, 3'b001);
    @(posedge clk); #1;
    check("a_pulse_end", {29'b0, ev0}, 0);
    for (int i = 1; i <= 3; i++) xfer(32'hCAFE_0000, 1, i, cyc, rdata, err);
    check("c_cnt", {16'b0, c0}, 3);
    check("c_pulse", {29'b0, ev0}, 3'b100);
    xfer(32'hCAFE_0000, 0, 32'hFFFF_FFFF, cyc, rdata, err);
    check("c_read", rdata, 32'h3);
    check("c_read_pulse", {29'b0, ev0}, 0);
    check("c_after_read", {16'b0, c0}, 3);
    xfer(32'hABBA_0000, 0, 0, cyc, rdata, err);
    check("a_read", rdata, 32'h1);
    xfer(32'hBAFF_0000, 1, 32'h7, cyc, rdata, err);
    xfer(32'hBAFF_0000, 1, 32'h0, cyc, rdata, err);
    check("b_cnt2", {16'b0, b0}, 2);
    check("b_pulse", {29'b0, ev0}, 3'b010);
    xfer(32'hBAFF_0000, 1, 32'h8000_0000, cyc, rdata, err);
    check("b_clear", {16'b0, b0}, 0);
    check("b_clear_pulse", {29'b0, ev0}, 0);
    xfer(32'h1234_0000, 1, 32'h1, cyc, rdata, err);
    check("unm_wr_serr", {31'b0, err}, 1);
    check("unm_wr_cnt", {a0, b0}, {16'd1, 16'd0});
    check("unm_wr_cnt_c", {16'b0, c0}, 3);
    check("unm_wr_pulse", {29'b0, ev0}, 0);
    xfer(32'hABBA_0004, 0, 0, cyc, rdata, err);
    check("unm_rd_serr", {31'b0, err}, 1);
    check("unm_rd_data", rdata, 0);
    check("perr_clean", {31'b0, perr0}, 0);
    psel[0] = 1; pen[0] = 0; paddr[0] = 32'hABBA_0000; pwr[0] = 1; pwdata[0] = 1;
    @(posedge clk); #1 psel[0] = 0;
    @(posedge clk); #1;
    check("abort_perr", {31'b0, perr0}, 1);
    check("abort_cnt", {16'b0, a0}, 1);
    check("abort_pulse", {29'b0, ev0}, 0);
    xfer(32'hABBA_0000, 1, 32'h1, cyc, rdata, err);
    check("post_abort_cnt", {16'b0, a0}, 2);
    check("perr_sticky", {31'b0, perr0}, 1);
    psel[0] = 1; pen[0] = 0; paddr[0] = 32'hABBA_0000; pwr[0] = 1; pwdata[0] = 1;
    @(posedge clk); #1 pen[0] = 1;
    #1 reset = 1'b0;
    #1;
    check("mid_rst_rdy", {31'b0, rdy0}, 0);
    check("mid_rst_cnt", {16'b0, a0}, 0);
    check("mid_rst_perr", {31'b0, perr0}, 0);
    check("mid_rst_ev", {29'b0, ev0}, 0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("stray_rdy", {31'b0, rdy0}, 0);
    @(posedge clk); #1;
    check("stray_cnt", {16'b0, a0}, 0);
    check("stray_perr", {31'b0, perr0}, 1);
    psel[0] = 0; pen[0] = 0;
    xfer(32'hABBA_0000, 1, 32'h1, cyc, rdata, err);
    check("rst_recover_cyc", cyc, 2);
    check("rst_recover_cnt", {16'b0, a0}, 1);
    cur = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      xfer(32'hABBA_0000, 1, 32'h1, cyc, rdata, err);
      if (i == 1) check("sat_pulse", {29'b0, ev1}, 3'b001);
      if (i == 3) check("sat_cnt3", {30'b0, a1}, 3);
    end
    check("sat_cnt5", {30'b0, a1}, 3);
    check("sat_cyc", cyc, 1);
    xfer(32'hABBA_0000, 0, 0, cyc, rdata, err);
    check("sat_read", rdata, 32'h3);
    xfer(32'hABBA_0000, 1, 32'h1, cyc, rdata, err);
    check("b2b_a_cyc", cyc, 1);
    check("b2b_a_pulse", {29'b0, ev1}, 3'b001);
    xfer(32'hBAFF_0000, 1, 32'h1, cyc, rdata, err);
    check("b2b_b_cyc", cyc, 1);
    check("b2b_b_pulse", {29'b0, ev1}, 3'b010);
    check("b2b_b_cnt", {30'b0, b1}, 1);
    check("b2b_perr", {31'b0, perr1}, 0);
    xfer(32'hBAFF_0000, 0, 0, cyc, rdata, err);
    check("w0_read_b", rdata, 32'h1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
